// File: rtl/det_sched.sv
// det_sched: round-robin scheduler sharing one serial 1010 Mealy detector
// among NCH byte channels with per-channel saved state. DET_NONOVERLAP_EN selects non-overlapping.
module det_sched #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NCH-1:0]           req_valid,
    input  logic [8*NCH-1:0]         req_data,
    output logic [NCH-1:0]           req_ready,
    input  logic [NCH-1:0]           ctx_clr,
    output logic                     rsp_valid,
    output logic [$clog2(NCH)-1:0]   rsp_ch,
    output logic [2:0]               rsp_hits,
    output logic [CNT_W-1:0]         rsp_total,
    output logic                     busy
);
    localparam int PW = $clog2(NCH);

    typedef enum logic [1:0] {IDLE, SHIFT, RESP} st_e;

    st_e              r_state;
    st_e              w_next;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_gnt;
    logic [7:0]       r_byte;
    logic [1:0]       r_work;
    logic [2:0]       r_bit;
    logic [2:0]       r_hits;
    logic             r_clr;
    logic [1:0]       r_st  [NCH];
    logic [CNT_W-1:0] r_tot [NCH];
    logic [PW-1:0]    r_rsp_ch;
    logic [2:0]       r_rsp_hits;
    logic [CNT_W-1:0] r_rsp_tot;

    logic             w_found;
    logic [PW-1:0]    w_gidx;
    logic [PW:0]      w_j;
    logic             w_bit;
    logic             w_hit;
    logic [1:0]       w_det_nxt;
    logic [CNT_W:0]   w_sum;
    logic             w_wclr;
    logic [CNT_W-1:0] w_new_tot;

    // Round-robin search for the first valid channel after ptr
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_j     = '0;
        for (int k = 1; k <= NCH; k++) begin
            w_j = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_j >= (PW+1)'(NCH))
                w_j = w_j - (PW+1)'(NCH);
            if (!w_found && req_valid[w_j[PW-1:0]]) begin
                w_found = 1'b1;
                w_gidx  = w_j[PW-1:0];
            end
        end
    end

    // Detector next state and hit flag for the current MSB
    always_comb begin
        w_bit     = r_byte[7];
        w_hit     = 1'b0;
        w_det_nxt = r_work;
        unique case (r_work)
            2'd0: w_det_nxt = w_bit ? 2'd1 : 2'd0;
            2'd1: w_det_nxt = w_bit ? 2'd1 : 2'd2;
            2'd2: w_det_nxt = w_bit ? 2'd3 : 2'd0;
            2'd3: begin
                if (w_bit) begin
                    w_det_nxt = 2'd1;
                end else begin
                    w_hit = 1'b1;
`ifdef DET_NONOVERLAP_EN
                    w_det_nxt = 2'd0;
`else
                    w_det_nxt = 2'd2;
`endif
                end
            end
        endcase
    end

    // Saturating write-back total, forced to zero by a clear
    always_comb begin
        w_sum     = {1'b0, r_tot[r_gnt]} + (CNT_W+1)'(r_hits);
        w_wclr    = r_clr | ctx_clr[r_gnt];
        w_new_tot = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
        if (w_wclr)
            w_new_tot = '0;
    end

    // Scheduler state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Scheduler next state and handshake/response outputs
    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        rsp_valid = 1'b0;
        busy      = (r_state != IDLE);
        rsp_ch    = r_rsp_ch;
        rsp_hits  = r_rsp_hits;
        rsp_total = r_rsp_tot;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    req_ready[w_gidx] = 1'b1;
                    w_next            = SHIFT;
                end
            end
            SHIFT: begin
                if (r_bit == 3'd7)
                    w_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_ch    = r_gnt;
                rsp_hits  = r_hits;
                rsp_total = w_new_tot;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Datapath: capture, bit-serial detection, context write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= PW'(NCH-1);
            r_gnt      <= '0;
            r_byte     <= '0;
            r_work     <= '0;
            r_bit      <= '0;
            r_hits     <= '0;
            r_clr      <= 1'b0;
            r_rsp_ch   <= '0;
            r_rsp_hits <= '0;
            r_rsp_tot  <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_st[i]  <= '0;
                r_tot[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ctx_clr[i]) begin
                    r_st[i]  <= '0;
                    r_tot[i] <= '0;
                end
            end
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_gnt  <= w_gidx;
                        r_byte <= req_data[8*w_gidx +: 8];
                        r_work <= ctx_clr[w_gidx] ? 2'd0 : r_st[w_gidx];
                        r_bit  <= '0;
                        r_hits <= '0;
                        r_clr  <= 1'b0;
                    end
                end
                SHIFT: begin
                    r_byte <= {r_byte[6:0], 1'b0};
                    r_work <= w_det_nxt;
                    r_bit  <= r_bit + 3'd1;
                    if (w_hit)
                        r_hits <= r_hits + 3'd1;
                    if (ctx_clr[r_gnt])
                        r_clr <= 1'b1;
                end
                RESP: begin
                    r_st[r_gnt]  <= w_wclr ? 2'd0 : r_work;
                    r_tot[r_gnt] <= w_new_tot;
                    r_rsp_ch     <= r_gnt;
                    r_rsp_hits   <= r_hits;
                    r_rsp_tot    <= w_new_tot;
                    r_ptr        <= r_gnt;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_det_sched.sv
// tb_det_sched: scoreboard bench for det_sched (NCH=4, CNT_W=4).
// Expected hits/totals are hand-computed for both detector modes.
module tb_det_sched;
    localparam int NCH = 4;
    localparam int CW  = 4;

`ifdef DET_NONOVERLAP_EN
    localparam int H_AA  = 2;
    localparam int H_AA2 = 2;
    localparam int H_40  = 1;
    int sat_hit[6] = '{2, 2, 2, 2, 2, 2};
    int sat_tot[6] = '{2, 4, 6, 8, 10, 12};
`else
    localparam int H_AA  = 3;
    localparam int H_AA2 = 4;
    localparam int H_40  = 2;
    int sat_hit[6] = '{3, 4, 4, 4, 4, 4};
    int sat_tot[6] = '{3, 7, 11, 15, 15, 15};
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NCH-1:0]    req_valid = '0;
    logic [8*NCH-1:0]  req_data = '0;
    logic [NCH-1:0]    req_ready;
    logic [NCH-1:0]    ctx_clr = '0;
    logic              rsp_valid;
    logic [1:0]        rsp_ch;
    logic [2:0]        rsp_hits;
    logic [CW-1:0]     rsp_total;
    logic              busy;

    typedef struct {
        int ch;
        int hits;
        int total;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    det_sched #(.NCH(NCH), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .ctx_clr   (ctx_clr),
        .rsp_valid (rsp_valid),
        .rsp_ch    (rsp_ch),
        .rsp_hits  (rsp_hits),
        .rsp_total (rsp_total),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pop one expectation per response pulse
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("rsp_ch", int'(rsp_ch), e.ch);
                chk("rsp_hits", int'(rsp_hits), e.hits);
                chk("rsp_total", int'(rsp_total), e.total);
                if (e.cyc >= 0)
                    chk("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic issue(input int ch, input logic [7:0] d, output int tc);
        int n;
        n = 0;
        @(negedge clk);
        req_data[8*ch +: 8] = d;
        req_valid[ch] = 1'b1;
        #1;
        while (!req_ready[ch] && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!req_ready[ch]) begin
            chk("grant_timeout", 0, 1);
            req_valid[ch] = 1'b0;
            tc = -1;
        end else begin
            @(posedge clk);
            #1;
            req_valid[ch] = 1'b0;
            tc = cyc;
        end
    endtask

    task automatic send(input int ch, input logic [7:0] d,
                        input int hits, input int tot);
        int tc;
        issue(ch, d, tc);
        if (tc >= 0)
            sb.push_back('{ch, hits, tot, tc + 8});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tc;
        int c;
        int lows;
        int tf[4];

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_total", int'(rsp_total), 0);
        rst_n = 1'b1;
        @(negedge clk);

        send(0, 8'hAA, H_AA, H_AA);
        drain();

        send(1, 8'h05, 0, 0);
        drain();
        send(2, 8'h00, 0, 0);
        drain();
        send(1, 8'h40, H_40, H_40);
        drain();

        issue(3, 8'hAA, tc);
        if (tc >= 0)
            sb.push_back('{3, H_AA, 0, tc + 8});
        repeat (4) @(negedge clk);
        ctx_clr = 4'b1000;
        @(negedge clk);
        ctx_clr = '0;
        drain();
        send(3, 8'h0A, 1, 1);
        drain();

        tf = '{H_AA, H_40, 0, 1};
        @(negedge clk);
        c = cyc;
        for (int k = 0; k < 8; k++)
            sb.push_back('{k % 4, 0, tf[k % 4], c + 9 + 10 * k});
        req_data  = '0;
        req_valid = 4'hF;
        lows = 0;
        for (int i = 0; i < 80; i++) begin
            if (!busy)
                lows++;
            @(negedge clk);
        end
        req_valid = '0;
        chk("fair_idle_cycles", lows, 8);
        drain();

        @(negedge clk);
        ctx_clr = 4'b0001;
        @(negedge clk);
        ctx_clr = '0;
        for (int k = 0; k < 6; k++) begin
            send(0, 8'hAA, sat_hit[k], sat_tot[k]);
            drain();
        end

        issue(2, 8'h00, tc);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", int'(req_ready), 0);
        chk("mid_rst_rsp_valid", int'(rsp_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ch", int'(rsp_ch), 0);
        chk("mid_rst_hits", int'(rsp_hits), 0);
        chk("mid_rst_total", int'(rsp_total), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);
        req_data  = '0;
        req_valid = 4'hF;
        #1;
        chk("post_rst_grant", int'(req_ready), 1);
        @(posedge clk);
        #1;
        req_valid = '0;
        sb.push_back('{0, 0, 0, cyc + 8});
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
